dmem_write_buffer: RTL and testbench

//   Sits between the single-cycle core's data-memory port and a slower multi-cycle backing data memory.
//   - Stores are posted into a DEPTH-entry FIFO and retire in one cycle unless the FIFO is full.
//   - Loads hit the buffer (youngest match forwarded) or go to memory through a req/ack handshake.
//   - Core is frozen via stall while a load miss or a full-buffer store is pending.

---
 rtl/dmem_write_buffer_pkg.sv | 16 +
 rtl/dmem_wb_fifo.sv | 94 +++++++++
 rtl/dmem_write_buffer.sv | 137 +++++++++++++
 tb/tb_dmem_write_buffer.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_write_buffer_pkg.sv
// Shared definitions for the data-memory write buffer.
//   - Default sizing for depth, word-address width and data width.
//   - Backing-memory sequencer state encoding.
package dmem_write_buffer_pkg;

  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefAw    = 7;
  localparam int unsigned DefDw    = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StLoad  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/dmem_wb_fifo.sv
// Posted-store FIFO with an address CAM.
//   clk, rst       clock, asynchronous active-high reset
//   push_i         store accepted this cycle (caller guarantees not full)
//   pop_i          retire the head entry
//   head_busy_i    head entry is (or is about to be) in flight; never coalesce into it
//   addr_i         store/load word address, shared by enqueue and lookup
//   data_i         store data
//   full_o/empty_o occupancy flags
//   head_addr_o/head_data_o  oldest entry
//   fwd_hit_o/fwd_data_o     youngest valid entry matching addr_i, head included
module dmem_wb_fifo
  import dmem_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DW    = DefDw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          head_busy_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  output logic          fwd_hit_o,
  output logic [DW-1:0] fwd_data_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW-1:0] count;
  logic [IW-1:0] rd_idx, wr_idx, cam_idx, coal_idx;
  logic          coal_hit;

  assign rd_idx  = rd_ptr_q[IW-1:0];
  assign wr_idx  = wr_ptr_q[IW-1:0];
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty_o = (rd_ptr_q == wr_ptr_q);
  // Same index, different lap bit: the writer is a full lap ahead.
  assign full_o  = (rd_ptr_q[IW] != wr_ptr_q[IW]) && (rd_idx == wr_idx);

  assign head_addr_o = addr_q[rd_idx];
  assign head_data_o = data_q[rd_idx];

  // Scan oldest to youngest so the last match wins for both forward and coalesce.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    coal_hit   = 1'b0;
    coal_idx   = '0;
    cam_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cam_idx = rd_idx + IW'(i);
      if ((PW'(i) < count) && (addr_q[cam_idx] == addr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[cam_idx];
        if (!((i == 0) && head_busy_i)) begin
          coal_hit = 1'b1;
          coal_idx = cam_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      if (coal_hit) begin
        data_q[coal_idx] <= data_i;
      end else begin
        addr_q[wr_idx] <= addr_i;
        data_q[wr_idx] <= data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push_i && !coal_hit) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)               rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Write buffer between a single-cycle core data port and a multi-cycle backing memory.
//   clk, rst                 clock, asynchronous active-high reset
//   CEN/WEN/OEN              core strobes, active-low (store: CEN=0,WEN=0; load: CEN=0,WEN=1,OEN=0)
//   A, Data2Mem              core word address and store data
//   ReadDataMem              load data (combinational; 0 when no load completes)
//   stall                    core freeze (combinational)
//   mem_req/mem_we/mem_addr/mem_wdata  registered request, held until mem_ack
//   mem_ack, mem_rdata       completion pulse and read data
//   idle                     buffer empty and no request outstanding
module dmem_write_buffer
  import dmem_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DW    = DefDw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] Data2Mem,
  output logic [DW-1:0] ReadDataMem,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          idle
);

  wb_state_e     state_q;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic          is_store, is_load, load_miss, load_ack;
  logic          push, pop, head_busy;
  logic          full, empty, fwd_hit;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data, fwd_data;

  assign is_store  = !CEN && !WEN;
  assign is_load   = !CEN && WEN && !OEN;
  assign load_miss = is_load && !fwd_hit;
  assign load_ack  = (state_q == StLoad) && mem_ack;
  assign push      = is_store && !full;
  assign pop       = (state_q == StDrain) && mem_ack;
  // Head is committed to memory once DRAIN starts, and IDLE with a non-empty FIFO latches it now.
  assign head_busy = (state_q == StDrain) || ((state_q == StIdle) && !empty);

  dmem_wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .head_busy_i (head_busy),
    .addr_i      (A),
    .data_i      (Data2Mem),
    .full_o      (full),
    .empty_o     (empty),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .fwd_hit_o   (fwd_hit),
    .fwd_data_o  (fwd_data)
  );

  // Full stalls even in the pop cycle; the store enqueues once the pointer has moved.
  assign stall = (is_store && full) || (load_miss && !load_ack);

  always_comb begin
    ReadDataMem = '0;
    if (is_load && fwd_hit) begin
      ReadDataMem = fwd_data;
    end else if (is_load && load_ack) begin
      ReadDataMem = mem_rdata;
    end
  end

  assign idle      = empty && (state_q == StIdle);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_miss) begin
            state_q    <= StLoad;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= A;
          end else if (!empty) begin
            state_q     <= StDrain;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= head_addr;
            mem_wdata_q <= head_data;
          end else if (push) begin
            // Empty buffer: the store being enqueued is the head, so start its write directly.
            state_q     <= StDrain;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= A;
            mem_wdata_q <= Data2Mem;
          end
        end
        StDrain, StLoad: begin
          if (mem_ack) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
module tb_dmem_write_buffer;

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk, rst;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem, ReadDataMem, mem_wdata, mem_rdata;
  logic        stall, mem_req, mem_we, mem_ack, idle;
  logic [6:0]  mem_addr;

  int   checks = 0;
  int   errors = 0;

  // Backing memory model: unwritten words read as 0xCAFE0000 | addr.
  logic [31:0] mem_model [128];
  bit          mem_wr_v  [128];
  wr_t         wr_log [$];
  logic [31:0] ref_mem [128];

  bit   ack_hold = 1'b1;
  bit   rand_ack = 1'b0;
  int   ack_delay = 0;
  logic man_ack = 1'b0;
  logic auto_ack = 1'b0;
  int   ack_cnt = 0;
  int   rnd_delay = 0;

  dmem_write_buffer u_dut (
    .clk         (clk),
    .rst         (rst),
    .CEN         (CEN),
    .WEN         (WEN),
    .OEN         (OEN),
    .A           (A),
    .Data2Mem    (Data2Mem),
    .ReadDataMem (ReadDataMem),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .idle        (idle)
  );

  function automatic logic [31:0] init_val(input logic [6:0] a);
    return {16'hCAFE, 9'd0, a};
  endfunction

  function automatic logic [31:0] mem_val(input logic [6:0] a);
    return mem_wr_v[a] ? mem_model[a] : init_val(a);
  endfunction

  assign mem_rdata = mem_val(mem_addr);
  assign mem_ack   = auto_ack | man_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: ack after a programmable number of request cycles.
  always @(posedge clk) begin
    #1;
    if (mem_req && !ack_hold && !rst) begin
      if (ack_cnt >= (rand_ack ? rnd_delay : ack_delay)) begin
        auto_ack  = 1'b1;
        ack_cnt   = 0;
        rnd_delay = $urandom_range(0, 3);
      end else begin
        auto_ack = 1'b0;
        ack_cnt++;
      end
    end else begin
      auto_ack = 1'b0;
      ack_cnt  = 0;
    end
  end

  // Commit completed writes into the memory model.
  always @(posedge clk) begin
    if (!rst && mem_req && mem_ack && mem_we) begin
      wr_log.push_back('{a: mem_addr, d: mem_wdata});
      mem_model[mem_addr] = mem_wdata;
      mem_wr_v[mem_addr]  = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_nop();
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; Data2Mem = '0;
  endtask

  task automatic set_store(input logic [6:0] a, input logic [31:0] d);
    CEN = 1'b0; WEN = 1'b0; OEN = 1'b1; A = a; Data2Mem = d;
  endtask

  task automatic set_load(input logic [6:0] a);
    CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = a; Data2Mem = '0;
  endtask

  // Let the buffer empty out; returns on a negedge.
  task automatic wait_idle(input int budget, input string tag);
    bit ok = 1'b0;
    set_nop();
    for (int i = 0; i < budget; i++) begin
      #2;
      if (idle === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle: idle=%b after %0d cycles, required 1", tag, idle, budget);
    end else begin
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_nop();
    #1 rst = 1'b1;
    #1;
    checks += 7;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", mem_req); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b required 0", mem_we); end
    if (mem_addr !== 7'd0) begin errors++; $display("FAIL rst_addr: got %h required 0", mem_addr); end
    if (mem_wdata !== 32'd0) begin
      errors++; $display("FAIL rst_wdata: got %h required 0", mem_wdata);
    end
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b required 0", stall); end
    if (ReadDataMem !== 32'd0) begin
      errors++; $display("FAIL rst_rdata: got %h required 0", ReadDataMem);
    end
    if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b required 1", idle); end
    step();
    step();
    rst = 1'b0;
    #2;
    checks++;
    if (idle !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL post_rst: idle=%b req=%b required 1/0", idle, mem_req);
    end
    step();
  endtask

  task automatic test_store_drain();
    int n0 = wr_log.size();
    int cyc;
    ack_hold = 1'b0; ack_delay = 2;
    set_store(7'd5, 32'hDEADBEEF);
    #2;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL st1_stall: got %b required 0", stall); end
    step();
    set_nop();
    #2;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 7'd5 || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL st1_req: req=%b we=%b addr=%h data=%h required 1/1/05/deadbeef",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    cyc = 1;
    while (mem_ack !== 1'b1 && cyc < 10) begin
      step(); #2; cyc++;
    end
    checks++;
    if (cyc != 3 || idle !== 1'b0) begin
      errors++; $display("FAIL st1_ack: ack in req cycle %0d idle=%b required 3/0", cyc, idle);
    end
    step();
    #2;
    checks++;
    if (idle !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL st1_idle: idle=%b req=%b required 1/0", idle, mem_req);
    end
    checks++;
    if (wr_log.size() != n0 + 1 || wr_log[n0] !== '{a: 7'd5, d: 32'hDEADBEEF}) begin
      errors++; $display("FAIL st1_mem: log size %0d required %0d", wr_log.size(), n0 + 1);
    end
    step();
  endtask

  task automatic test_load_forward();
    bit saw_read = 1'b0;
    ack_hold = 1'b1;
    set_store(7'd9, 32'h11);
    #2;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL fwd_st_stall: got %b required 0", stall); end
    step();
    set_load(7'd9);
    #2;
    checks++;
    if (ReadDataMem !== 32'h11 || stall !== 1'b0) begin
      errors++; $display("FAIL fwd_hit: data=%h stall=%b required 00000011/0", ReadDataMem, stall);
    end
    for (int i = 0; i < 3; i++) begin
      if (mem_req === 1'b1 && mem_we !== 1'b1) saw_read = 1'b1;
      step(); #2;
    end
    checks++;
    if (saw_read || mem_addr !== 7'd9 || mem_we !== 1'b1) begin
      errors++; $display("FAIL fwd_noread: read_seen=%b addr=%h required 0/09", saw_read, mem_addr);
    end
    set_nop();
    ack_hold = 1'b0; ack_delay = 0;
    step();
    wait_idle(20, "fwd");
  endtask

  task automatic test_load_miss();
    int stall_cyc = 0;
    int n0 = wr_log.size();
    ack_hold = 1'b0; ack_delay = 1;
    set_store(7'd5, 32'h55);
    #2;
    step();
    set_load(7'd3);
    #2;
    while (stall === 1'b1 && stall_cyc < 20) begin
      stall_cyc++; step(); #2;
    end
    // Drain ack in 2nd cycle, one IDLE cycle, read ack in 2nd LOAD cycle.
    checks++;
    if (stall_cyc != 4) begin
      errors++; $display("FAIL miss_stall_len: got %0d cycles required 4", stall_cyc);
    end
    checks++;
    if (ReadDataMem !== 32'hCAFE0003) begin
      errors++; $display("FAIL miss_data: got %h required cafe0003", ReadDataMem);
    end
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 7'd3 || mem_ack !== 1'b1) begin
      errors++; $display("FAIL miss_req: req=%b we=%b addr=%h ack=%b required 1/0/03/1",
                         mem_req, mem_we, mem_addr, mem_ack);
    end
    checks++;
    if (wr_log.size() != n0 + 1 || wr_log[n0] !== '{a: 7'd5, d: 32'h55}) begin
      errors++; $display("FAIL miss_drain_first: log size %0d required %0d", wr_log.size(), n0 + 1);
    end
    step();
    wait_idle(20, "miss");
  endtask

  task automatic test_full_stall();
    int n0 = wr_log.size();
    logic [6:0]  ea [5] = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd10};
    ack_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_store(ea[i], 32'h100 + 32'(ea[i]));
      #2;
      checks++;
      if (stall !== 1'b0) begin
        errors++; $display("FAIL full_fill%0d: stall=%b required 0", i, stall);
      end
      step();
    end
    set_store(7'd10, 32'h10A);
    #2;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b required 1", stall); end
    step();
    man_ack = 1'b1;
    #2;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL full_pop_cycle: got %b required 1", stall); end
    step();
    man_ack = 1'b0;
    #2;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL full_enq: got %b required 0", stall); end
    checks++;
    if (wr_log.size() != n0 + 1) begin
      errors++; $display("FAIL full_pop: log size %0d required %0d", wr_log.size(), n0 + 1);
    end
    step();
    ack_hold = 1'b0; ack_delay = 0;
    wait_idle(40, "full");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_log.size() <= n0 + i) begin
        errors++; $display("FAIL full_order%0d: missing write, log size %0d", i, wr_log.size());
      end else if (wr_log[n0 + i] !== '{a: ea[i], d: 32'h100 + 32'(ea[i])}) begin
        errors++; $display("FAIL full_order%0d: got %h:%h required %h:%h", i, wr_log[n0 + i].a,
                           wr_log[n0 + i].d, ea[i], 32'h100 + 32'(ea[i]));
      end
    end
  endtask

  task automatic test_coalesce();
    int n0 = wr_log.size();
    int cyc = 0;
    logic [6:0]  sa [6] = '{7'd20, 7'd21, 7'd21, 7'd22, 7'd23, 7'd24};
    logic [31:0] sd [6] = '{32'd1, 32'd2, 32'd5, 32'd6, 32'd7, 32'd8};
    logic [6:0]  ea [5] = '{7'd20, 7'd21, 7'd22, 7'd23, 7'd24};
    logic [31:0] ed [5] = '{32'd1, 32'd5, 32'd6, 32'd7, 32'd8};
    ack_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_store(sa[i], sd[i]);
      #2;
      checks++;
      if (stall !== 1'b0) begin
        errors++; $display("FAIL coal_st%0d: stall=%b required 0", i, stall);
      end
      step();
    end
    set_store(sa[5], sd[5]);
    #2;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL coal_full: stall=%b required 1", stall); end
    ack_hold = 1'b0; ack_delay = 0;
    while (stall === 1'b1 && cyc < 20) begin
      step(); #2; cyc++;
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL coal_release: stall stuck at 1"); end
    step();
    wait_idle(40, "coal");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_log.size() <= n0 + i || wr_log[n0 + i] !== '{a: ea[i], d: ed[i]}) begin
        errors++; $display("FAIL coal_order%0d: log size %0d, required %h:%h", i, wr_log.size(),
                           ea[i], ed[i]);
      end
    end
    checks++;
    if (wr_log.size() != n0 + 5) begin
      errors++; $display("FAIL coal_count: %0d writes required 5", wr_log.size() - n0);
    end
  endtask

  task automatic test_inflight_dup();
    int n0 = wr_log.size();
    logic [6:0]  ea [3] = '{7'd7, 7'd8, 7'd7};
    logic [31:0] ed [3] = '{32'd1, 32'd2, 32'd3};
    ack_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_store(ea[i], ed[i]);
      step();
    end
    set_load(7'd7);
    #2;
    checks++;
    if (ReadDataMem !== 32'd3 || stall !== 1'b0) begin
      errors++; $display("FAIL dup_fwd: data=%h stall=%b required 00000003/0", ReadDataMem, stall);
    end
    step();
    ack_hold = 1'b0; ack_delay = 1;
    wait_idle(40, "dup");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_log.size() <= n0 + i || wr_log[n0 + i] !== '{a: ea[i], d: ed[i]}) begin
        errors++; $display("FAIL dup_order%0d: log size %0d, required %h:%h", i, wr_log.size(),
                           ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int n0;
    int cyc = 0;
    ack_hold = 1'b1;
    set_store(7'd5, 32'h77);
    step();
    set_nop();
    #2;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rs_pre: req=%b required 1", mem_req); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || idle !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 7'd0) begin
      errors++; $display("FAIL rs_async: req=%b idle=%b we=%b addr=%h required 0/1/0/00",
                         mem_req, idle, mem_we, mem_addr);
    end
    step();
    rst = 1'b0;
    n0 = wr_log.size();
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    #2;
    checks++;
    if (idle !== 1'b1 || mem_req !== 1'b0 || wr_log.size() != n0) begin
      errors++; $display("FAIL rs_stray_ack: idle=%b req=%b writes=%0d required 1/0/0",
                         idle, mem_req, wr_log.size() - n0);
    end
    step();
    // The discarded store must not be visible: memory still holds the earlier 0x55.
    ack_hold = 1'b0; ack_delay = 0;
    set_load(7'd5);
    #2;
    while (stall === 1'b1 && cyc < 20) begin
      step(); #2; cyc++;
    end
    checks++;
    if (ReadDataMem !== 32'h55 || stall !== 1'b0) begin
      errors++; $display("FAIL rs_discard: data=%h stall=%b required 00000055/0", ReadDataMem, stall);
    end
    step();
    wait_idle(20, "rs");
  endtask

  task automatic test_random();
    logic [6:0]  a;
    logic [31:0] d;
    logic [39:0] prev_bus = '0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    int          kind, cyc;
    bit          done;
    for (int i = 0; i < 128; i++) ref_mem[i] = mem_val(7'(i));
    rand_ack = 1'b1;
    ack_hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      a    = 7'($urandom_range(0, 15));
      d    = $urandom;
      if (kind < 5)       set_store(a, d);
      else if (kind < 8)  set_load(a);
      else if (kind == 8) set_nop();
      else begin
        CEN = 1'b0; WEN = 1'b1; OEN = 1'b1; A = a; Data2Mem = d;
      end
      done = 1'b0;
      cyc  = 0;
      while (!done) begin
        #2;
        if (prev_req && !prev_ack && mem_req === 1'b1) begin
          checks++;
          if ({mem_we, mem_addr, mem_wdata} !== prev_bus) begin
            errors++; $display("FAIL rnd_hold: request changed %h -> %h while pending",
                               prev_bus, {mem_we, mem_addr, mem_wdata});
          end
        end
        prev_req = mem_req;
        prev_ack = mem_ack;
        prev_bus = {mem_we, mem_addr, mem_wdata};
        if (stall !== 1'b1) begin
          done = 1'b1;
        end else if (cyc >= 30) begin
          checks++; errors++;
          $display("FAIL rnd_stall: op %0d stalled over 30 cycles", n);
          done = 1'b1;
        end else begin
          cyc++;
          step();
        end
      end
      if (kind < 5) begin
        ref_mem[a] = d;
      end else if (kind < 8) begin
        checks++;
        if (ReadDataMem !== ref_mem[a]) begin
          errors++; $display("FAIL rnd_load: op %0d addr %h got %h required %h", n, a,
                             ReadDataMem, ref_mem[a]);
        end
      end else begin
        checks++;
        if (ReadDataMem !== 32'd0) begin
          errors++; $display("FAIL rnd_nop: op %0d data %h required 0", n, ReadDataMem);
        end
      end
      step();
    end
    wait_idle(200, "rnd");
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem_val(7'(i)) !== ref_mem[i]) begin
        errors++; $display("FAIL rnd_final: addr %0d mem %h required %h", i, mem_val(7'(i)),
                           ref_mem[i]);
      end
    end
    rand_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_drain();
    test_load_forward();
    test_load_miss();
    test_full_stall();
    test_coalesce();
    test_inflight_dup();
    test_reset_inflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
